// File: rtl/uart_rx_frame.sv
// uart_rx_frame: parametrised UART receiver with input synchroniser,
// start-bit glitch rejection, parity/framing checks and break hold.
module uart_rx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int CNT_W      = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CNT_W-1:0]     clks_per_bit,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int   BW     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic LP_PEN = (PARITY_EN != 0);
    localparam logic LP_ODD = (PARITY_ODD != 0);
    localparam logic LP_TWO = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                 r_sync1;
    logic                 r_sync2;
    logic [CNT_W-1:0]     r_cpb;
    logic [CNT_W-1:0]     r_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [BW-1:0]        r_bit_idx;
    logic                 r_par;
    logic                 r_stop_idx;
    logic                 r_ferr;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_valid;
    logic                 r_perr_out;
    logic                 r_ferr_out;

    logic                 w_rx_s;
    logic [CNT_W-1:0]     w_cpb_in;
    logic [CNT_W-1:0]     w_mid;
    logic [CNT_W-1:0]     w_last;
    logic                 w_wrap;
    logic                 w_mid_hit;
    logic                 w_last_bit;
    logic                 w_last_stop;
    logic                 w_busy;
    logic                 w_shift;
    logic                 w_par_smp;
    logic                 w_stop_smp;
    logic                 w_done;
    logic                 w_perr;

    assign w_rx_s   = r_sync2;
    assign w_cpb_in = (clks_per_bit < CNT_W'(2)) ? CNT_W'(2) : clks_per_bit;
    assign w_mid    = (r_cpb >> 1) - CNT_W'(1);
    assign w_last   = r_cpb - CNT_W'(1);

    assign w_wrap = ((r_state == S_DATA) ||
                     (r_state == S_PARITY) ||
                     (r_state == S_STOP)) && (r_cnt == w_last);

    assign w_mid_hit   = (r_state == S_START) && (r_cnt == w_mid);
    assign w_last_bit  = (r_bit_idx == BW'(DATA_BITS - 1));
    assign w_last_stop = ~LP_TWO | r_stop_idx;
    assign w_perr      = LP_PEN & ((^r_shift ^ LP_ODD) != r_par);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_serial;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (!w_rx_s) w_next = S_START;
            end
            S_START: begin
                if (w_mid_hit) w_next = w_rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_wrap && w_last_bit)
                    w_next = LP_PEN ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (w_wrap) w_next = S_STOP;
            end
            S_STOP: begin
                if (w_wrap && w_last_stop)
                    w_next = w_rx_s ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                if (w_rx_s) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy     = 1'b1;
        w_shift    = 1'b0;
        w_par_smp  = 1'b0;
        w_stop_smp = 1'b0;
        w_done     = 1'b0;
        unique case (r_state)
            S_IDLE:   w_busy = 1'b0;
            S_DATA:   w_shift = w_wrap;
            S_PARITY: w_par_smp = w_wrap;
            S_STOP: begin
                w_stop_smp = w_wrap;
                w_done     = w_wrap && w_last_stop;
            end
            default: ;
        endcase
    end

    // Bit period is frozen at frame start so rate changes only apply next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cpb <= CNT_W'(2);
        end else if ((r_state == S_IDLE) && (w_next == S_START)) begin
            r_cpb <= w_cpb_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((r_state == S_IDLE) || (w_next != r_state) || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_par      <= 1'b0;
            r_stop_idx <= 1'b0;
            r_ferr     <= 1'b0;
            r_rx_data  <= '0;
            r_valid    <= 1'b0;
            r_perr_out <= 1'b0;
            r_ferr_out <= 1'b0;
        end else begin
            if (r_state == S_START) begin
                r_bit_idx  <= '0;
                r_stop_idx <= 1'b0;
                r_ferr     <= 1'b0;
            end
            if (w_shift) begin
                r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                r_bit_idx <= r_bit_idx + BW'(1);
            end
            if (w_par_smp) begin
                r_par <= w_rx_s;
            end
            if (w_stop_smp) begin
                r_stop_idx <= ~r_stop_idx;
                if (!w_rx_s) r_ferr <= 1'b1;
            end
            r_valid <= w_done;
            if (w_done) begin
                r_rx_data  <= r_shift;
                r_perr_out <= w_perr;
                r_ferr_out <= r_ferr | ~w_rx_s;
            end
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_valid;
    assign parity_err = r_perr_out;
    assign frame_err  = r_ferr_out;
    assign busy       = w_busy;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed bench driving four receiver configurations
// (default, even parity, odd parity, two stop bits).
module tb_uart_rx_frame;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [15:0] cpb = 16'd16;
    logic [3:0] rx_line = 4'hF;
    logic [7:0] rxd [4];
    logic [3:0] vld;
    logic [3:0] perr;
    logic [3:0] ferr;
    logic [3:0] bsy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vcnt [4] = '{default: 0};
    int vlast [4] = '{default: 0};
    int vprev [4] = '{default: 0};
    logic [7:0] vdlast [4] = '{default: 8'h00};
    logic [7:0] vdprev [4] = '{default: 8'h00};

    typedef struct {
        int         d;
        logic [7:0] data;
        logic       pbit;
        logic [1:0] stops;
        int         cpb_in;
        int         blen;
        logic [7:0] exp_d;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    vec_t tbl [10];

    uart_rx_frame #(.DATA_BITS(8), .CNT_W(16), .PARITY_EN(0),
                    .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .clks_per_bit(cpb), .rx_serial(rx_line[0]),
        .rx_data(rxd[0]), .rx_valid(vld[0]), .parity_err(perr[0]),
        .frame_err(ferr[0]), .busy(bsy[0]));

    uart_rx_frame #(.DATA_BITS(8), .CNT_W(16), .PARITY_EN(1),
                    .PARITY_ODD(0), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .clks_per_bit(cpb), .rx_serial(rx_line[1]),
        .rx_data(rxd[1]), .rx_valid(vld[1]), .parity_err(perr[1]),
        .frame_err(ferr[1]), .busy(bsy[1]));

    uart_rx_frame #(.DATA_BITS(8), .CNT_W(16), .PARITY_EN(1),
                    .PARITY_ODD(1), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst), .clks_per_bit(cpb), .rx_serial(rx_line[2]),
        .rx_data(rxd[2]), .rx_valid(vld[2]), .parity_err(perr[2]),
        .frame_err(ferr[2]), .busy(bsy[2]));

    uart_rx_frame #(.DATA_BITS(8), .CNT_W(16), .PARITY_EN(0),
                    .PARITY_ODD(0), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .clks_per_bit(cpb), .rx_serial(rx_line[3]),
        .rx_data(rxd[3]), .rx_valid(vld[3]), .parity_err(perr[3]),
        .frame_err(ferr[3]), .busy(bsy[3]));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (vld[i]) begin
                vcnt[i]   = vcnt[i] + 1;
                vprev[i]  = vlast[i];
                vlast[i]  = cyc;
                vdprev[i] = vdlast[i];
                vdlast[i] = rxd[i];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Cycle in which rx_valid is high, given the cycle the start bit is driven.
    function automatic int exp_cyc(input int k, input int d, input int blen);
        int nb;
        nb = 8 + (((d == 1) || (d == 2)) ? 1 : 0) + ((d == 3) ? 2 : 1);
        return k + 4 + (blen / 2 - 1) + nb * blen;
    endfunction

    task automatic send(input int d, input logic [7:0] data,
                        input logic pbit, input logic [1:0] stops,
                        input int blen, input int chg_bit,
                        input int chg_val, input int rst_bit,
                        output int k);
        logic [11:0] bits;
        int n;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = data[i];
        n = 9;
        if ((d == 1) || (d == 2)) begin
            bits[n] = pbit;
            n++;
        end
        bits[n] = stops[0];
        n++;
        if (d == 3) begin
            bits[n] = stops[1];
            n++;
        end
        k = cyc;
        for (int b = 0; b < n; b++) begin
            if (b == chg_bit) cpb = 16'(chg_val);
            rx_line[d] = bits[b];
            for (int c = 0; c < blen; c++) begin
                rst = (b == rst_bit) && (c == 0);
                tick();
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        int k;
        int k2;
        int n0;
        int d;

        tbl[0] = '{0, 8'hA5, 1'b0, 2'b11, 16, 16, 8'hA5, 1'b0, 1'b0};
        tbl[1] = '{1, 8'h07, 1'b0, 2'b11, 16, 16, 8'h07, 1'b1, 1'b0};
        tbl[2] = '{1, 8'h07, 1'b1, 2'b11, 16, 16, 8'h07, 1'b0, 1'b0};
        tbl[3] = '{2, 8'h07, 1'b0, 2'b11, 16, 16, 8'h07, 1'b0, 1'b0};
        tbl[4] = '{2, 8'h07, 1'b1, 2'b11, 16, 16, 8'h07, 1'b1, 1'b0};
        tbl[5] = '{3, 8'h55, 1'b0, 2'b11, 16, 16, 8'h55, 1'b0, 1'b0};
        tbl[6] = '{3, 8'h55, 1'b0, 2'b10, 16, 16, 8'h55, 1'b0, 1'b1};
        tbl[7] = '{0, 8'h5A, 1'b0, 2'b11, 1, 2, 8'h5A, 1'b0, 1'b0};
        tbl[8] = '{0, 8'hFF, 1'b0, 2'b11, 0, 2, 8'hFF, 1'b0, 1'b0};
        tbl[9] = '{0, 8'h96, 1'b0, 2'b11, 3, 3, 8'h96, 1'b0, 1'b0};

        rst = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst%0d_data", i), rxd[i], 0);
            chk($sformatf("rst%0d_valid", i), vld[i], 0);
            chk($sformatf("rst%0d_perr", i), perr[i], 0);
            chk($sformatf("rst%0d_ferr", i), ferr[i], 0);
            chk($sformatf("rst%0d_busy", i), bsy[i], 0);
        end
        rst = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 10; i++) begin
            d = tbl[i].d;
            cpb = 16'(tbl[i].cpb_in);
            n0 = vcnt[d];
            send(d, tbl[i].data, tbl[i].pbit, tbl[i].stops,
                 tbl[i].blen, -1, 0, -1, k);
            rx_line[d] = 1'b1;
            repeat (3 * tbl[i].blen + 8) tick();
            chk($sformatf("v%0d_count", i), vcnt[d] - n0, 1);
            chk($sformatf("v%0d_cycle", i), vlast[d],
                exp_cyc(k, d, tbl[i].blen));
            chk($sformatf("v%0d_data", i), rxd[d], tbl[i].exp_d);
            chk($sformatf("v%0d_perr", i), perr[d], tbl[i].exp_pe);
            chk($sformatf("v%0d_ferr", i), ferr[d], tbl[i].exp_fe);
            chk($sformatf("v%0d_busy", i), bsy[d], 0);
        end

        // Start-bit glitch
        cpb = 16'd16;
        n0 = vcnt[0];
        rx_line[0] = 1'b0;
        repeat (4) tick();
        rx_line[0] = 1'b1;
        chk("glitch_busy_hi", bsy[0], 1);
        repeat (30) tick();
        chk("glitch_count", vcnt[0] - n0, 0);
        chk("glitch_busy_lo", bsy[0], 0);
        send(0, 8'h3C, 1'b0, 2'b11, 16, -1, 0, -1, k);
        repeat (56) tick();
        chk("glitch_next_count", vcnt[0] - n0, 1);
        chk("glitch_next_data", rxd[0], 8'h3C);
        chk("glitch_next_cycle", vlast[0], exp_cyc(k, 0, 16));

        // Framing error then held-low break
        n0 = vcnt[3];
        send(3, 8'h55, 1'b0, 2'b01, 16, -1, 0, -1, k);
        repeat (100) tick();
        chk("brk_count", vcnt[3] - n0, 1);
        chk("brk_cycle", vlast[3], exp_cyc(k, 3, 16));
        chk("brk_data", rxd[3], 8'h55);
        chk("brk_ferr", ferr[3], 1);
        chk("brk_busy_hi", bsy[3], 1);
        rx_line[3] = 1'b1;
        repeat (10) tick();
        chk("brk_busy_lo", bsy[3], 0);
        send(3, 8'h81, 1'b0, 2'b11, 16, -1, 0, -1, k);
        repeat (56) tick();
        chk("brk_next_count", vcnt[3] - n0, 2);
        chk("brk_next_data", rxd[3], 8'h81);
        chk("brk_next_ferr", ferr[3], 0);

        // Rate change during data bit 3
        n0 = vcnt[0];
        cpb = 16'd16;
        send(0, 8'hC3, 1'b0, 2'b11, 16, 4, 8, -1, k);
        repeat (56) tick();
        chk("rate_count", vcnt[0] - n0, 1);
        chk("rate_data", rxd[0], 8'hC3);
        chk("rate_cycle", vlast[0], exp_cyc(k, 0, 16));
        send(0, 8'h3A, 1'b0, 2'b11, 8, -1, 0, -1, k);
        repeat (32) tick();
        chk("rate8_count", vcnt[0] - n0, 2);
        chk("rate8_data", rxd[0], 8'h3A);
        chk("rate8_cycle", vlast[0], exp_cyc(k, 0, 8));

        // Reset mid-data
        cpb = 16'd16;
        n0 = vcnt[0];
        send(0, 8'hFF, 1'b0, 2'b11, 16, -1, 0, 3, k);
        repeat (20) tick();
        chk("mrst_count", vcnt[0] - n0, 0);
        chk("mrst_data", rxd[0], 0);
        chk("mrst_perr", perr[0], 0);
        chk("mrst_ferr", ferr[0], 0);
        chk("mrst_busy", bsy[0], 0);
        chk("mrst_data3", rxd[3], 0);

        // Back-to-back with no idle gap
        n0 = vcnt[0];
        send(0, 8'h12, 1'b0, 2'b11, 16, -1, 0, -1, k);
        send(0, 8'h34, 1'b0, 2'b11, 16, -1, 0, -1, k2);
        repeat (56) tick();
        chk("b2b_count", vcnt[0] - n0, 2);
        chk("b2b_gap", vlast[0] - vprev[0], 160);
        chk("b2b_cycle", vlast[0], exp_cyc(k2, 0, 16));
        chk("b2b_first", vdprev[0], 8'h12);
        chk("b2b_second", vdlast[0], 8'h34);
        chk("b2b_ferr", ferr[0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receive engine; successor to the fixed-format RX bit counter and state machine. Width, parity, stop-bit count and counter width are generic. Bit period is programmable at run time. Adds input synchronisation, start-bit glitch rejection, parity and framing checks, and break-hold handling. Sits between the board RX pin and the command/data decoder.

## Interface
- `DATA_BITS`, default 8: payload bits per frame, legal 5..9, sent LSB first.
- `CNT_W`, default 16: width of the bit-period counter and of `clks_per_bit`.
- `PARITY_EN`, default 0: 1 means a parity bit follows the data.
- `PARITY_ODD`, default 0: 0 is even parity, 1 is odd; ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1: legal values 1 or 2.
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `clks_per_bit` in `CNT_W`: clk cycles per bit. Values below 2 are treated as 2.
- `rx_serial` in 1: asynchronous line, idles high.
- `rx_data` out `DATA_BITS`: last received payload.
- `rx_valid` out 1: one-cycle pulse when a frame completes.
- `parity_err` out 1: parity mismatch for the frame flagged by `rx_valid`.
- `frame_err` out 1: a stop bit was sampled low.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- `rx_serial` passes through a 2-flop synchroniser to give `rx_s`. The synchroniser flops reset to 1. All decisions use `rx_s`.
- `cpb_l` is latched from max(`clks_per_bit`, 2) on the IDLE→START transition. Changes to `clks_per_bit` mid-frame are ignored.
- `mid` = (`cpb_l` >> 1) − 1.
- Counter `cnt` is `CNT_W` bits.
  - It is forced to 0 in IDLE and on every state transition.
  - Otherwise it increments by 1.
  - It wraps to 0 when `cnt` == `cpb_l`−1 in DATA, PARITY and STOP.
- States and transitions:
  - IDLE: when `rx_s`==0, go to START.
  - START: at `cnt`==`mid`, go to DATA if `rx_s`==0. If `rx_s`==1 it is a glitch: go to IDLE with no output.
  - DATA: at each wrap, shift `rx_s` in at the MSB of a `DATA_BITS` shift register, giving LSB-first order. After `DATA_BITS` samples, go to PARITY if `PARITY_EN`, else STOP.
  - PARITY: at the wrap, store the sampled bit and go to STOP.
  - STOP: sample at each wrap, `STOP_BITS` times.
    - Any low stop sample sets the frame's framing error.
    - After the last stop sample, complete the frame.
    - If the final stop sample was low, go to BREAK; otherwise go to IDLE.
  - BREAK: stay until `rx_s`==1, then go to IDLE. This prevents a held-low line from retriggering.
- Parity check: computed = XOR(data) XOR `PARITY_ODD`. The error is (computed ≠ received bit).
- Frame completion, on the same edge as the last stop sample:
  - `rx_data`, `parity_err` and `frame_err` load the new values.
  - `rx_valid` is set for exactly one cycle.
  - `rx_valid` asserts even when an error is flagged.
- `rx_data`, `parity_err` and `frame_err` hold their values until the next completion.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0. State is IDLE, `cnt`=0, and the synchroniser holds 1.
- Reset mid-frame aborts the frame with no `rx_valid`.
- Input latency: a `rx_serial` edge reaches `rx_s` 2 cycles later.
- Let t0 be the first cycle in START. `rx_valid` is high in cycle t0 + (`mid`+1) + (`DATA_BITS` + `PARITY_EN` + `STOP_BITS`)·`cpb_l`.
- Data samples fall at mid-bit ±1 cycle relative to the synchronised edge.
- Back-to-back frames: a start bit whose low level reaches `rx_s` in the cycle after the return to IDLE is accepted. No dead cycles beyond that one.
- Every comparison is made against `cpb_l`. Counter overflow cannot occur while `cpb_l` ≤ 2^`CNT_W`−1.

## Test plan
- **Nominal frame:** defaults, `clks_per_bit`=16, send 0xA5 with 1 stop bit. Required: `rx_data`=0xA5, one `rx_valid` pulse at the computed cycle, `parity_err`=0, `frame_err`=0, `busy` low afterwards.
- **Glitch rejection:** drive `rx_serial` low for 4 cycles, then high (`clks_per_bit`=16). Required: no `rx_valid`, `busy` drops back to 0, and the next 0x3C frame decodes correctly.
- **Parity:** `PARITY_EN`=1, even parity, send 0x07 with parity bit 0. Required: `rx_valid`, `rx_data`=0x07, `parity_err`=1. Resending with parity bit 1 gives `parity_err`=0. Repeat with `PARITY_ODD`=1 and the expected results inverted.
- **Framing and break:** `STOP_BITS`=2, send 0x55 with the second stop bit low, then hold the line low for 100 cycles. Required: `frame_err`=1 with a single `rx_valid`, and no further `rx_valid` while the line is low. After release high, 0x81 decodes cleanly.
- **Rate change mid-frame:** change `clks_per_bit` 16→8 during bit 3 of 0xC3. Required: the frame decodes as 0xC3 at 16 cycles/bit, and the following frame is decoded at 8 cycles/bit.
- **Reset and back-to-back:** assert `rst` for 1 cycle mid-data. Required: all outputs 0 and no `rx_valid`. Then send frames 0x12 and 0x34 with zero idle gap: two `rx_valid` pulses, exactly 10·16 cycles apart.
